// File: rtl/ldpc_qc_parity_enc_if.sv
// rtl/ldpc_qc_parity_enc_if.sv - handshake, ROM and parity stream bundle for the QC-LDPC parity encoder
interface ldpc_qc_parity_enc_if #(
  parameter int Z  = 360,
  parameter int AW = 4
);
  logic          start;
  logic          din_valid;
  logic          din;
  logic          din_ready;
  logic [AW-1:0] rom_addr;
  logic [Z-1:0]  rom_data;
  logic          dout;
  logic          dout_valid;
  logic          dout_last;
  logic          dout_ready;
  logic          busy;

  modport master (
    output start, din_valid, din, rom_data, dout_ready,
    input  din_ready, rom_addr, dout, dout_valid, dout_last, busy
  );

  modport slave (
    input  start, din_valid, din, rom_data, dout_ready,
    output din_ready, rom_addr, dout, dout_valid, dout_last, busy
  );
endinterface

// File: rtl/ldpc_qc_parity_enc.sv
// rtl/ldpc_qc_parity_enc.sv - serial QC-LDPC parity encoder with circulant generator ROM
module ldpc_qc_parity_enc #(
  parameter int Z             = 360,
  parameter int KG            = 12,
  parameter int AW            = 4,
  parameter int OUT_MSB_FIRST = 1,
  parameter int ACCUM_MODE    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ldpc_qc_parity_enc_if.slave  bus
);
  localparam int JW = (Z > 1) ? $clog2(Z) : 1;

  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_D, ACCUM, OUTPUT} state_t;

  state_t        state_q, state_d;
  logic [Z-1:0]  acc_q, acc_d;
  logic [Z-1:0]  rot_q, rot_d;
  logic [AW-1:0] g_q, g_d;
  logic [JW-1:0] j_q, j_d;
  logic [JW-1:0] k_q, k_d;
  logic          run_q, run_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_last_q, dout_last_d;

  logic [JW-1:0] sel_idx;
  logic          sel_bit;
  logic          load;
  logic          done;

  // Pick the accumulator bit for output index k in the configured bit order
  assign sel_idx = (OUT_MSB_FIRST != 0) ? (JW'(Z - 1) - k_q) : k_q;
  assign sel_bit = acc_q[sel_idx];
  // A new bit is loaded into the output register when it is empty or the current non-last bit is taken
  assign load    = (state_q == OUTPUT) && (!dout_valid_q || (bus.dout_ready && !dout_last_q));
  assign done    = (state_q == OUTPUT) && dout_valid_q && dout_last_q && bus.dout_ready;

  assign bus.din_ready  = (state_q == ACCUM);
  assign bus.busy       = (state_q != IDLE);
  assign bus.rom_addr   = rom_addr_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;

  // Next-state and datapath updates for fetch, accumulate and serialize phases
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    rot_d        = rot_q;
    g_d          = g_q;
    j_d          = j_q;
    k_d          = k_q;
    run_d        = run_q;
    rom_addr_d   = rom_addr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d      = '0;
          run_d      = 1'b0;
          g_d        = '0;
          j_d        = '0;
          k_d        = '0;
          rom_addr_d = '0;
          state_d    = FETCH_A;
        end
      end
      FETCH_A: state_d = FETCH_D;
      FETCH_D: begin
        rot_d   = bus.rom_data;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (bus.din_valid) begin
          if (bus.din) acc_d = acc_q ^ rot_q;
          rot_d = {rot_q[0], rot_q[Z-1:1]};
          if (j_q == JW'(Z - 1)) begin
            if (g_q == AW'(KG - 1)) begin
              k_d     = '0;
              state_d = OUTPUT;
            end else begin
              j_d        = '0;
              g_d        = g_q + AW'(1);
              rom_addr_d = g_q + AW'(1);
              state_d    = FETCH_A;
            end
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
      OUTPUT: begin
        if (done) begin
          dout_d       = 1'b0;
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          state_d      = IDLE;
        end else if (load) begin
          dout_d       = (ACCUM_MODE != 0) ? (run_q ^ sel_bit) : sel_bit;
          run_d        = run_q ^ sel_bit;
          dout_valid_d = 1'b1;
          dout_last_d  = (k_q == JW'(Z - 1));
          if (k_q != JW'(Z - 1)) k_d = k_q + JW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any codeword in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      rot_q        <= '0;
      g_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      run_q        <= 1'b0;
      rom_addr_q   <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      rot_q        <= rot_d;
      g_q          <= g_d;
      j_q          <= j_d;
      k_q          <= k_d;
      run_q        <= run_d;
      rom_addr_q   <= rom_addr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end
endmodule

// File: tb/tb_ldpc_qc_parity_enc.sv
// tb/tb_ldpc_qc_parity_enc.sv - directed bench for the QC-LDPC parity encoder (three output configurations)
module tb_ldpc_qc_parity_enc;
  localparam int Z  = 8;
  localparam int KG = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_r = 1'b0;
  logic din_valid_r = 1'b0;
  logic din_r = 1'b0;
  logic dout_ready_r = 1'b0;
  logic [Z-1:0] rom [0:(1<<AW)-1];

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // u0: MSB first raw, u1: LSB first raw, u2: MSB first running XOR
  ldpc_qc_parity_enc_if #(.Z(Z), .AW(AW)) b0 ();
  ldpc_qc_parity_enc_if #(.Z(Z), .AW(AW)) b1 ();
  ldpc_qc_parity_enc_if #(.Z(Z), .AW(AW)) b2 ();

  assign b0.start = start_r;  assign b0.din_valid = din_valid_r;  assign b0.din = din_r;  assign b0.dout_ready = dout_ready_r;
  assign b1.start = start_r;  assign b1.din_valid = din_valid_r;  assign b1.din = din_r;  assign b1.dout_ready = dout_ready_r;
  assign b2.start = start_r;  assign b2.din_valid = din_valid_r;  assign b2.din = din_r;  assign b2.dout_ready = dout_ready_r;

  // Synchronous generator ROMs
  always @(posedge clk) begin
    b0.rom_data <= rom[b0.rom_addr];
    b1.rom_data <= rom[b1.rom_addr];
    b2.rom_data <= rom[b2.rom_addr];
  end

  ldpc_qc_parity_enc #(.Z(Z), .KG(KG), .AW(AW), .OUT_MSB_FIRST(1), .ACCUM_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  ldpc_qc_parity_enc #(.Z(Z), .KG(KG), .AW(AW), .OUT_MSB_FIRST(0), .ACCUM_MODE(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ldpc_qc_parity_enc #(.Z(Z), .KG(KG), .AW(AW), .OUT_MSB_FIRST(1), .ACCUM_MODE(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic pulse_start();
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    vec++;
    if (b0.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start got=%b want=1", b0.busy);
    end
  endtask

  // Feed 16 info bits (index = g*8+j); optional gaps, a stray start at start_at, reset at abort_at
  task automatic send_bits(input logic [15:0] bits, input bit gaps, input int start_at, input int abort_at);
    int idx;
    int cyc;
    bit pulsed;
    idx = 0; cyc = 0; pulsed = 0;
    while (idx < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start_r = 1'b0;
      if (idx == abort_at) begin
        rst_n = 1'b0;
        din_valid_r = 1'b0;
        #1;
        vec++;
        if ({b0.busy, b0.din_ready, b0.dout, b0.dout_valid, b0.dout_last, b0.rom_addr} !== '0) begin
          bad++;
          $display("FAIL abort_reset_outputs got=%b want=0", {b0.busy, b0.din_ready, b0.dout, b0.dout_valid, b0.dout_last, b0.rom_addr});
        end
        @(negedge clk);
        vec++;
        if ({b0.busy, b0.dout_valid, b1.dout_valid, b2.dout_valid} !== 4'b0) begin
          bad++;
          $display("FAIL abort_reset_hold got=%b want=0", {b0.busy, b0.dout_valid, b1.dout_valid, b2.dout_valid});
        end
        rst_n = 1'b1;
        return;
      end
      if (idx == start_at && !pulsed) begin
        start_r = 1'b1;
        pulsed = 1;
      end
      din_valid_r = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      din_r = bits[idx];
      if (din_valid_r && b0.din_ready) idx++;
    end
    @(negedge clk);
    din_valid_r = 1'b0;
    start_r = 1'b0;
    vec++;
    if (idx !== 16) begin
      bad++;
      $display("FAIL send_timeout got=%0d want=16", idx);
    end
  endtask

  // Collect Z parity bits from all three encoders; optional 3-cycle stall at output index stall_k
  task automatic collect(input int stall_k, output logic [7:0] s0, output logic [7:0] s1, output logic [7:0] s2);
    int n;
    int cyc;
    int stall;
    logic held;
    n = 0; cyc = 0; stall = 0; held = 1'b0;
    s0 = '0; s1 = '0; s2 = '0;
    dout_ready_r = 1'b1;
    while (n < Z && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (b0.dout_valid === 1'b1) begin
        if (n == stall_k && stall < 3) begin
          if (stall == 0) held = b0.dout;
          else begin
            vec++;
            if (b0.dout !== held || b0.dout_valid !== 1'b1 || b0.dout_last !== 1'b0) begin
              bad++;
              $display("FAIL stall_hold got=%b%b%b want=%b10", b0.dout, b0.dout_valid, b0.dout_last, held);
            end
          end
          dout_ready_r = 1'b0;
          stall++;
        end else begin
          dout_ready_r = 1'b1;
          s0[Z-1-n] = b0.dout;
          s1[Z-1-n] = b1.dout;
          s2[Z-1-n] = b2.dout;
          vec++;
          if (b0.dout_last !== (n == Z - 1)) begin
            bad++;
            $display("FAIL dout_last k=%0d got=%b want=%b", n, b0.dout_last, (n == Z - 1));
          end
          n++;
        end
      end
    end
    vec++;
    if (n !== Z) begin
      bad++;
      $display("FAIL collect_timeout got=%0d want=%0d", n, Z);
    end
    @(negedge clk);
    vec++;
    if ({b0.dout_valid, b0.busy, b1.busy, b2.busy} !== 4'b0) begin
      bad++;
      $display("FAIL post_codeword_idle got=%b want=0000", {b0.dout_valid, b0.busy, b1.busy, b2.busy});
    end
  endtask

  task automatic check_seq(input string name, input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    vec++;
    if (s0 !== e0) begin bad++; $display("FAIL %s msb_raw got=%h want=%h", name, s0, e0); end
    vec++;
    if (s1 !== e1) begin bad++; $display("FAIL %s lsb_raw got=%h want=%h", name, s1, e1); end
    vec++;
    if (s2 !== e2) begin bad++; $display("FAIL %s msb_accum got=%h want=%h", name, s2, e2); end
  endtask

  task automatic test_reset();
    logic [7:0] s0, s1, s2;
    rst_n = 1'b0;
    start_r = 1'b1;
    din_valid_r = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({b0.busy, b0.din_ready, b0.dout, b0.dout_valid, b0.dout_last, b0.rom_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {b0.busy, b0.din_ready, b0.dout, b0.dout_valid, b0.dout_last, b0.rom_addr});
    end
    start_r = 1'b0;
    din_valid_r = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vec++;
    if ({b0.busy, b0.din_ready} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=00", {b0.busy, b0.din_ready});
    end
    s0 = '0; s1 = '0; s2 = '0;
  endtask

  task automatic test_zero();
    logic [7:0] s0, s1, s2;
    pulse_start();
    send_bits(16'h0000, 1'b0, -1, -1);
    collect(-1, s0, s1, s2);
    check_seq("zero", s0, s1, s2, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_single_bit();
    logic [7:0] s0, s1, s2;
    pulse_start();
    send_bits(16'h0002, 1'b0, -1, -1);
    collect(-1, s0, s1, s2);
    check_seq("single_bit", s0, s1, s2, 8'h80, 8'h01, 8'hFF);
  endtask

  task automatic test_backpressure();
    logic [7:0] s0, s1, s2;
    pulse_start();
    send_bits(16'h0002, 1'b0, -1, -1);
    collect(3, s0, s1, s2);
    check_seq("backpressure", s0, s1, s2, 8'h80, 8'h01, 8'hFF);
  endtask

  // bits 0,3 (row0 rotations 0x01,0x20) and bit 13 (row1 rotated 5 -> 0x04): acc = 0x25
  task automatic test_multi_bit();
    logic [7:0] s0, s1, s2;
    pulse_start();
    send_bits(16'h2009, 1'b0, -1, -1);
    collect(-1, s0, s1, s2);
    check_seq("multi_bit", s0, s1, s2, 8'h25, 8'hA4, 8'h39);
  endtask

  task automatic test_gaps_start();
    logic [7:0] s0, s1, s2;
    pulse_start();
    send_bits(16'h2009, 1'b1, 4, -1);
    collect(-1, s0, s1, s2);
    check_seq("gaps_start", s0, s1, s2, 8'h25, 8'hA4, 8'h39);
  endtask

  task automatic test_reset_abort();
    logic [7:0] s0, s1, s2;
    pulse_start();
    send_bits(16'h2009, 1'b0, -1, 5);
    @(negedge clk);
    vec++;
    if ({b0.busy, b0.dout_valid} !== 2'b00) begin
      bad++;
      $display("FAIL abort_idle got=%b want=00", {b0.busy, b0.dout_valid});
    end
    pulse_start();
    send_bits(16'h0002, 1'b0, -1, -1);
    collect(-1, s0, s1, s2);
    check_seq("after_abort", s0, s1, s2, 8'h80, 8'h01, 8'hFF);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
    rom[0] = 8'h01;
    rom[1] = 8'h80;
    test_reset();
    test_zero();
    test_single_bit();
    test_backpressure();
    test_multi_bit();
    test_gaps_start();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/ldpc_qc_parity_enc.md
LDPC_QC_PARITY_ENC -- requirements
Module: ldpc_qc_parity_enc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter Z, default 360: circulant size, and the width of the parity accumulator and of each ROM row.
REQ-003 Parameter KG, default 12: number of information groups per codeword; the codeword has Z*KG information bits.
REQ-004 Parameter AW, default 4: ROM address width; KG SHALL be <= 2^AW.
REQ-005 Parameter OUT_MSB_FIRST, default 1: 1 = parity bit Z-1 is emitted first; 0 = bit 0 is emitted first.
REQ-006 Parameter ACCUM_MODE, default 0: 1 = emit the running XOR (IRA accumulator) of the parity bits in output order instead of the raw parity bits.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  one-cycle pulse that begins a codeword; it is accepted only in IDLE.
REQ-010 din_valid  in  1  the information bit on din is valid.
REQ-011 din  in  1  serial information bit.
REQ-012 din_ready  out  1  the block accepts din this cycle; a transfer occurs when din_valid and din_ready are both high.
REQ-013 rom_addr  out  AW  registered address of the generator ROM row (one row per group).
REQ-014 rom_data  in  Z  generator ROM row; the ROM is synchronous, so data is valid one cycle after rom_addr is sampled.
REQ-015 dout  out  1  serial parity bit.
REQ-016 dout_valid  out  1  dout is valid.
REQ-017 dout_last  out  1  dout is the final parity bit of the codeword.
REQ-018 dout_ready  in  1  the sink accepts dout.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, FETCH_A, FETCH_D, ACCUM and OUTPUT.
REQ-021 IDLE: on start, clear acc, set group g=0 and bit count j=0, drive rom_addr=0, and go to FETCH_A; start is ignored in every other state.
REQ-022 FETCH_A lasts one cycle while the ROM samples rom_addr; FETCH_D lasts one cycle, loads rot<=rom_data, and goes to ACCUM; din_ready SHALL be 0 in both states.
REQ-023 ACCUM: din_ready=1; on each transfer, if din=1 then acc<=acc^rot; always rot<={rot[0],rot[Z-1:1]} and j<=j+1.
REQ-024 din_valid=0 in ACCUM SHALL stall the block with no state change; gaps of any length are legal.
REQ-025 On the transfer with j=Z-1 and g<KG-1: j<=0, g<=g+1, rom_addr<=g+1, then go to FETCH_A.
REQ-026 On the transfer with j=Z-1 and g=KG-1: go to OUTPUT with output index k=0; the XOR for that final bit is included in acc.
REQ-027 OUTPUT: dout = acc[Z-1-k] when OUT_MSB_FIRST=1, or acc[k] when OUT_MSB_FIRST=0; dout_valid=1.
REQ-028 With ACCUM_MODE=1, dout SHALL equal the XOR of the selected bits for indices 0..k; the running state is cleared on start.
REQ-029 dout, dout_valid and dout_last SHALL hold stable while dout_valid=1 and dout_ready=0, and k advances only on a handshake.
REQ-030 dout_last=1 exactly when k=Z-1; the handshake on that bit SHALL return the FSM to IDLE, with dout_valid=0 on the next cycle.
REQ-031 dout, dout_valid and dout_last SHALL be registered, and dout_valid appears on the cycle after the FSM enters OUTPUT.
REQ-032 Counter widths: j SHALL be ceil(log2 Z) bits and g SHALL be AW bits, with no wrap beyond the terminal values above.
REQ-033 din_ready SHALL be 0 in IDLE and OUTPUT; din_valid in those states is ignored.

Reset
REQ-034 While rst_n=0: state=IDLE; acc, rot, g, j, k, the running XOR and rom_addr SHALL be 0; din_ready, dout, dout_valid, dout_last and busy SHALL be 0.
REQ-035 Reset asserted in any state, including mid-ACCUM or mid-OUTPUT, SHALL abort the codeword immediately; no partial parity is emitted after reset.

Verification (Z=8, KG=2, ROM row0=8'h01, row1=8'h80, OUT_MSB_FIRST=1 unless stated)
REQ-036 Scenario 1: start, then 16 zero info bits -> 8 dout bits all 0, dout_last only on the 8th, busy=0 afterwards.
REQ-037 Scenario 2: info bit index 1 = 1 (group 0, j=1), all others 0 -> acc=8'h80, dout sequence 1,0,0,0,0,0,0,0; with OUT_MSB_FIRST=0 the sequence is 0,0,0,0,0,0,0,1.
REQ-038 Scenario 3: ACCUM_MODE=1 with the scenario-2 input -> dout sequence 1,1,1,1,1,1,1,1.
REQ-039 Scenario 4: dout_ready held low for 3 cycles at k=3 -> dout and dout_valid are unchanged for those cycles, and no bit is lost or duplicated.
REQ-040 Scenario 5: random din_valid gaps, plus start pulsed during ACCUM -> parity is identical to the gap-free run, and the extra start is ignored.
REQ-041 Scenario 6: rst_n pulsed low at info bit 5, then a fresh codeword -> outputs are 0 during reset, and the new parity matches the reference model with no residue from the aborted codeword.
